// File: rtl/quat_pkg.sv
// Shared quaternion definitions: default fixed-point format and the Hamilton
// product term table (operand pairing and signs).
package quat_pkg;

  localparam int QUAT_W    = 16;
  localparam int QUAT_FRAC = 8;

  // Bit (4*k + j) set means term x_j * b_idx is subtracted in output k.
  localparam logic [15:0] QUAT_NEG_TBL = 16'b0100_0010_1000_1110;

  // The b component paired with x_j in output k is always b_(k xor j).
  function automatic logic [1:0] quat_bidx(input int k, input int j);
    return 2'(k ^ j);
  endfunction

  function automatic logic quat_term_neg(input int k, input int j, input logic conj);
    return QUAT_NEG_TBL[k*4+j] ^ (conj && (quat_bidx(k, j) != 2'd0));
  endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Half-up rounding of a wide fixed-point sum by FRAC bits, then saturation
// to a W-bit signed result with a clamp flag.
module fx_round_sat #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic signed [2*W+1:0] sum,
  output logic signed [W-1:0]   y,
  output logic                  sat
);

  localparam int SW = 2*W+2;
  localparam logic signed [SW-1:0] MAXV = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [SW-1:0] rounded;

  generate
    if (FRAC > 0) begin : g_round
      localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC-1);
      logic signed [SW-1:0] biased;
      always_comb begin
        biased  = sum + HALF;
        rounded = biased >>> FRAC;
      end
    end else begin : g_pass
      assign rounded = sum;
    end
  endgenerate

  always_comb begin
    y   = rounded[W-1:0];
    sat = 1'b0;
    if (rounded > MAXV) begin
      y   = {1'b0, {(W-1){1'b1}}};
      sat = 1'b1;
    end else if (rounded < MINV) begin
      y   = {1'b1, {(W-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/quat_mul_pipe.sv
// Three-stage pipelined fixed-point quaternion multiplier (x*b or x*conj(b))
// with a valid/ready handshake; the whole pipe stalls on output backpressure.
module quat_mul_pipe
  import quat_pkg::*;
#(
  parameter int W    = QUAT_W,
  parameter int FRAC = QUAT_FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] x2,
  input  logic signed [W-1:0] x3,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] b3,
  input  logic                in_conj,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y0,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic signed [W-1:0] y3,
  output logic [3:0]          out_sat
);

  localparam int PW = 2*W;
  localparam int SW = 2*W+2;

  logic                 advance;
  logic                 v1, v2;
  logic signed [W-1:0]  xa [4];
  logic signed [W-1:0]  ba [4];
  logic signed [PW-1:0] prod_d [4][4];
  logic signed [PW-1:0] prod_q [4][4];
  logic signed [SW-1:0] sum_d [4];
  logic signed [SW-1:0] sum_q [4];
  logic signed [W-1:0]  rs_y [4];
  logic [3:0]           rs_sat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    xa[0] = x0; xa[1] = x1; xa[2] = x2; xa[3] = x3;
    ba[0] = b0; ba[1] = b1; ba[2] = b2; ba[3] = b3;
  end

  // Signs (including the conjugate) are applied to full-width products so a
  // most-negative operand never overflows.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        prod_d[k][j] = quat_term_neg(k, j, in_conj)
                     ? -(PW'(xa[j]) * PW'(ba[quat_bidx(k, j)]))
                     :  (PW'(xa[j]) * PW'(ba[quat_bidx(k, j)]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      prod_q <= '{default: '0};
    end else if (advance) begin
      v1     <= in_valid;
      prod_q <= prod_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum_d[k] = SW'(prod_q[k][0]) + SW'(prod_q[k][1])
               + SW'(prod_q[k][2]) + SW'(prod_q[k][3]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      sum_q <= '{default: '0};
    end else if (advance) begin
      v2    <= v1;
      sum_q <= sum_d;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_rs
    fx_round_sat #(.W(W), .FRAC(FRAC)) u_rs (
      .sum (sum_q[k]),
      .y   (rs_y[k]),
      .sat (rs_sat[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      out_sat   <= '0;
    end else if (advance) begin
      out_valid <= v2;
      y0        <= rs_y[0];
      y1        <= rs_y[1];
      y2        <= rs_y[2];
      y3        <= rs_y[3];
      out_sat   <= rs_sat;
    end
  end

endmodule

// File: tb/tb_quat_mul_pipe.sv
// Directed bench for quat_mul_pipe at W=16, FRAC=8 (1.0 = 0x0100): products,
// rounding, saturation, streaming, backpressure and mid-flight reset.
module tb_quat_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, in_conj, out_valid, out_ready;
  logic [15:0] x0, x1, x2, x3, b0, b1, b2, b3, y0, y1, y2, y3;
  logic [3:0]  out_sat;

  int errors = 0;
  int checks = 0;

  logic [31:0] expq [$];
  logic [31:0] e;
  int sent, got, first, last, stale;
  logic stall, prev_stall;
  logic [15:0] held0, held1, n;

  always #5 clk = ~clk;

  quat_mul_pipe #(.W(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .in_conj(in_conj),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_sat(out_sat)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic setOperands(input logic [15:0] a0, a1, a2, a3, c0, c1, c2, c3,
                             input logic conj);
    x0 = a0; x1 = a1; x2 = a2; x3 = a3;
    b0 = c0; b1 = c1; b2 = c2; b3 = c3;
    in_conj = conj;
  endtask

  // Present one operand set, then wait until its result should be visible.
  task automatic applyStimulus(input logic [15:0] a0, a1, a2, a3, c0, c1, c2, c3,
                               input logic conj);
    setOperands(a0, a1, a2, a3, c0, c1, c2, c3, conj);
    in_valid = 1'b1;
    #1 check("accept.in_ready", {15'b0, in_ready}, 16'h0001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("latency.early", {15'b0, out_valid}, 16'h0000);
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] e0, e1, e2, e3,
                             input logic [3:0] esat);
    check({tag, ".valid"}, {15'b0, out_valid}, 16'h0001);
    check({tag, ".y0"}, y0, e0);
    check({tag, ".y1"}, y1, e1);
    check({tag, ".y2"}, y2, e2);
    check({tag, ".y3"}, y3, e3);
    check({tag, ".sat"}, {12'b0, out_sat}, {12'b0, esat});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    setOperands(0, 0, 0, 0, 0, 0, 0, 0, 1'b0);

    #2;
    check("reset.out_valid", {15'b0, out_valid}, 16'h0000);
    check("reset.in_ready", {15'b0, in_ready}, 16'h0001);
    check("reset.y0", y0, 16'h0000);
    check("reset.sat", {12'b0, out_sat}, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    checkOutput("ident", 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'b0000);
    applyStimulus(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1'b1);
    checkOutput("conj", 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 4'b0000);
    applyStimulus(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    checkOutput("satpos", 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
    applyStimulus(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    checkOutput("satneg", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
    applyStimulus(16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0180, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    checkOutput("round1", 16'h00C0, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    applyStimulus(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    checkOutput("round2", 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    checkOutput("roundneg", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    // (1,2,3,4)*(5,6,7,8) = (-60,12,30,24); with conj(b) = (70,8,0,16)
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b0);
    checkOutput("general", 16'hC400, 16'h0C00, 16'h1E00, 16'h1800, 4'b0000);
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b1);
    checkOutput("generalconj", 16'h4600, 16'h0800, 16'h0000, 16'h1000, 4'b0000);
    applyStimulus(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b1);
    checkOutput("conjmin", 16'h8000, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
    applyStimulus(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b0);
    checkOutput("negmin", 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
    @(posedge clk); #1;

    // Back-to-back stream: x0=n, b0=1, b1=2 gives y0=n, y1=2n.
    sent = 0; got = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("streamA.y0", y0, e[31:16]);
          check("streamA.y1", y1, e[15:0]);
        end else begin
          check("streamA.extra", 16'h0001, 16'h0000);
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (sent < 8) begin
        n = 16'(sent + 1);
        setOperands(n << 8, 0, 0, 0, 16'h0100, 16'h0200, 0, 0, 1'b0);
        in_valid = 1'b1;
        expq.push_back({n << 8, n << 9});
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("streamA.first", 16'(first), 16'd3);
    check("streamA.last", 16'(last), 16'd10);
    check("streamA.count", 16'(got), 16'd8);

    // Stream with a 5-cycle consumer stall.
    expq.delete();
    sent = 0; got = 0; prev_stall = 1'b0; held0 = '0; held1 = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(posedge clk); #1;
      stall = (cyc >= 5) && (cyc < 10);
      out_ready = !stall;
      if (sent < 8) begin
        n = 16'(sent + 11);
        setOperands(n << 8, 0, 0, 0, 16'h0100, 16'h0200, 0, 0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall) begin
        check("stall.in_ready", {15'b0, in_ready}, 16'h0000);
        if (prev_stall) begin
          check("stall.valid", {15'b0, out_valid}, 16'h0001);
          check("stall.y0", y0, held0);
          check("stall.y1", y1, held1);
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back({n << 8, n << 9});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("streamB.y0", y0, e[31:16]);
          check("streamB.y1", y1, e[15:0]);
        end else begin
          check("streamB.extra", 16'h0001, 16'h0000);
        end
        got++;
      end
      held0 = y0; held1 = y1; prev_stall = stall;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("streamB.count", 16'(got), 16'd8);
    check("streamB.sent", 16'(sent), 16'd8);
    check("streamB.left", 16'(expq.size()), 16'd0);

    // Reset with one result held at the output and another behind it.
    @(posedge clk); #1;
    out_ready = 1'b0;
    setOperands(16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    setOperands(16'h0200, 0, 0, 0, 16'h0100, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst.pre.valid", {15'b0, out_valid}, 16'h0001);
    check("rst.pre.y0", y0, 16'h0100);
    rst = 1'b1;
    #1;
    check("rst.out_valid", {15'b0, out_valid}, 16'h0000);
    check("rst.y0", y0, 16'h0000);
    check("rst.sat", {12'b0, out_sat}, 16'h0000);
    check("rst.in_ready", {15'b0, in_ready}, 16'h0001);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("rst.stale", 16'(stale), 16'd0);

    applyStimulus(16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1'b0);
    checkOutput("postrst", 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
